// File: rtl/cdb_arbiter.sv
// cdb_arbiter: producer end of the CDB -> ROB completion interface.
//
// Each functional unit pushes completed results (ROB tag + value) into its own
// small FIFO. Every cycle one non-empty FIFO head is chosen round-robin, popped,
// and broadcast on a registered CDB (valid, tag, value) the following cycle.
// A squash empties every FIFO and kills the broadcast that would have been
// launched at that edge.
//
// Ports:
//   clock         rising-edge clock
//   reset         synchronous, active-low reset
//   fu_valid      per-FU result valid
//   fu_rob_tag    per-FU ROB tag, FU i at [i*ROB_TAG_W +: ROB_TAG_W]; tag 0 is dropped
//   fu_value      per-FU result value, FU i at [i*XLEN +: XLEN]
//   fu_ready      per-FU FIFO can accept this cycle
//   squash_valid  mispredict flush
//   cdb_valid     broadcast valid
//   cdb_rob_tag   broadcast ROB tag (0 when cdb_valid=0)
//   cdb_value     broadcast value (0 when cdb_valid=0)
//
// Optional feature: define CDB_ARBITER_READY_BYPASS_EN to let a full FIFO accept
// a new result in the same cycle its head is popped.

module cdb_arbiter #(
  parameter int unsigned NUM_FU     = 4,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned ROB_TAG_W  = 4,
  parameter int unsigned XLEN       = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_FU-1:0]         fu_valid,
  input  logic [NUM_FU*ROB_TAG_W-1:0] fu_rob_tag,
  input  logic [NUM_FU*XLEN-1:0]    fu_value,
  output logic [NUM_FU-1:0]         fu_ready,
  input  logic                      squash_valid,
  output logic                      cdb_valid,
  output logic [ROB_TAG_W-1:0]      cdb_rob_tag,
  output logic [XLEN-1:0]           cdb_value
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned PW  = AW + 1;
  localparam int unsigned RRW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  // FIFO state
  logic [PW-1:0]        wr_ptr_q [NUM_FU];
  logic [PW-1:0]        wr_ptr_d [NUM_FU];
  logic [PW-1:0]        rd_ptr_q [NUM_FU];
  logic [PW-1:0]        rd_ptr_d [NUM_FU];
  logic [ROB_TAG_W-1:0] tag_mem_q [NUM_FU][FIFO_DEPTH];
  logic [XLEN-1:0]      val_mem_q [NUM_FU][FIFO_DEPTH];

  logic [NUM_FU-1:0]    fifo_empty;
  logic [NUM_FU-1:0]    fifo_full;
  logic [ROB_TAG_W-1:0] head_tag [NUM_FU];
  logic [XLEN-1:0]      head_val [NUM_FU];
  logic [NUM_FU-1:0]    push;
  logic [NUM_FU-1:0]    pop;

  // Arbitration
  logic [RRW-1:0]       rr_ptr_q;
  logic [RRW-1:0]       rr_ptr_d;
  logic [NUM_FU-1:0]    grant;
  logic                 grant_any;
  logic [RRW-1:0]       grant_idx;
  logic [RRW:0]         cand_sum;

  // Output register
  logic                 cdb_valid_q;
  logic [ROB_TAG_W-1:0] cdb_tag_q;
  logic [XLEN-1:0]      cdb_val_q;
  logic                 launch;

  // FIFO status and head read
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      fifo_empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      fifo_full[i]  = (wr_ptr_q[i][PW-1] != rd_ptr_q[i][PW-1]) &&
                      (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
      head_tag[i]   = tag_mem_q[i][rd_ptr_q[i][AW-1:0]];
      head_val[i]   = val_mem_q[i][rd_ptr_q[i][AW-1:0]];
    end
  end

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_FU
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    cand_sum  = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      cand_sum = {1'b0, rr_ptr_q} + (RRW+1)'(k);
      if (cand_sum >= (RRW+1)'(NUM_FU)) begin
        cand_sum = cand_sum - (RRW+1)'(NUM_FU);
      end
      if (!grant_any && !fifo_empty[cand_sum[RRW-1:0]]) begin
        grant_any                  = 1'b1;
        grant_idx                  = cand_sum[RRW-1:0];
        grant[cand_sum[RRW-1:0]]   = 1'b1;
      end
    end
  end

  always_comb begin
    if (squash_valid) begin
      rr_ptr_d = '0;
    end else if (grant_any) begin
      rr_ptr_d = (grant_idx == RRW'(NUM_FU - 1)) ? '0 : grant_idx + RRW'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Ready, push/pop and pointer updates
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
`ifdef CDB_ARBITER_READY_BYPASS_EN
      // Slot freed by this cycle's pop may be refilled at the same edge
      fu_ready[i] = !fifo_full[i] || (grant[i] && !squash_valid);
`else
      fu_ready[i] = !fifo_full[i];
`endif
      pop[i]  = grant[i] && !squash_valid;
      // Tag 0 completes the handshake but is never stored
      push[i] = fu_valid[i] && fu_ready[i] && !squash_valid &&
                (fu_rob_tag[i*ROB_TAG_W +: ROB_TAG_W] != '0);
      if (squash_valid) begin
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
      end else begin
        wr_ptr_d[i] = push[i] ? wr_ptr_q[i] + PW'(1) : wr_ptr_q[i];
        rd_ptr_d[i] = pop[i]  ? rd_ptr_q[i] + PW'(1) : rd_ptr_q[i];
      end
    end
  end

  assign launch = grant_any && !squash_valid;

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_FU; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_val_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
      end
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= launch;
      cdb_tag_q   <= launch ? head_tag[grant_idx] : '0;
      cdb_val_q   <= launch ? head_val[grant_idx] : '0;
    end
  end

  // Storage needs no reset: contents are only visible through valid pointers
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (reset && push[i]) begin
        tag_mem_q[i][wr_ptr_q[i][AW-1:0]] <= fu_rob_tag[i*ROB_TAG_W +: ROB_TAG_W];
        val_mem_q[i][wr_ptr_q[i][AW-1:0]] <= fu_value[i*XLEN +: XLEN];
      end
    end
  end

  assign cdb_valid   = cdb_valid_q;
  assign cdb_rob_tag = cdb_tag_q;
  assign cdb_value   = cdb_val_q;

endmodule
